// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared definitions for the UART command-frame sequencer.
//   state_t           : parser state encoding (S_HUNT=0, S_LEN=1, S_DATA=2, S_CSUM=3)
//   SYNC_BYTE_DEFAULT : default frame start marker
//   LEN_W             : width of the LEN field / payload byte count
package uart_frame_pkg;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         LEN_W             = 4;

endpackage

// File: rtl/uart_frame_timeout.sv
// uart_frame_timeout: inter-byte watchdog for the frame parser.
//   i_Clock  : system clock
//   i_Rst_n  : asynchronous active-low reset
//   i_Load   : arm the watchdog with a fresh interval (a byte arrived mid-frame)
//   i_Clr    : disarm the watchdog (idle, or a byte that ends the frame)
//   o_Expire : combinational pulse in the cycle the interval runs out
// Loadable down-counter: 0 means disarmed, so the interval is loaded as
// TIMEOUT_CLKS and expiry is flagged on the count of 1. That places the
// expiry cycle TIMEOUT_CLKS-1 clocks after the load, as an elapsed-count
// comparison against TIMEOUT_CLKS-1 would.
module uart_frame_timeout #(
  parameter int TIMEOUT_CLKS = 8720
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Load,
  input  logic i_Clr,
  output logic o_Expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt <= '0;
    end else if (i_Load) begin
      cnt <= CNT_W'(TIMEOUT_CLKS);
    end else if (i_Clr) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A load or clear in the expiry cycle means a byte arrived: the byte wins.
  assign o_Expire = (cnt == CNT_W'(1)) && !i_Load && !i_Clr;

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: turns the UART receiver byte stream into checksummed
// command frames (SYNC, LEN, LEN payload bytes, XOR checksum) and presents
// whole frames downstream on a valid/ready handshake.
//   i_Clock / i_Rst_n    : clock, asynchronous active-low reset
//   i_Rx_DV / i_Rx_Byte  : one-cycle byte strobe and byte from the UART receiver
//   o_Valid / i_Ready    : frame handshake to the consumer
//   o_Payload / o_Len    : held frame, byte 0 in [7:0], unused bytes zero
//   o_Err                : one-cycle pulse on length, checksum, timeout or overrun
//   o_Busy               : parser is inside a frame
// Build option UART_FRAME_STATS_EN adds i_Cnt_Clr and the saturating error
// counters o_Cnt_Csum_Err, o_Cnt_Timeout and o_Cnt_Overrun.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN      = 6,
  parameter int         TIMEOUT_CLKS = 8720
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_DV,
  input  logic [7:0]           i_Rx_Byte,
  output logic                 o_Valid,
  input  logic                 i_Ready,
  output logic [MAX_LEN*8-1:0] o_Payload,
  output logic [LEN_W-1:0]     o_Len,
  output logic                 o_Err,
  output logic                 o_Busy
`ifdef UART_FRAME_STATS_EN
  ,
  input  logic                 i_Cnt_Clr,
  output logic [7:0]           o_Cnt_Csum_Err,
  output logic [7:0]           o_Cnt_Timeout,
  output logic [7:0]           o_Cnt_Overrun
`endif
);

  state_t                 state;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       idx;
  logic [7:0]             csum;
  logic [MAX_LEN*8-1:0]   work_buf;

  logic len_ok, csum_ok, out_free, next_busy;
  logic len_err, csum_err, ovr_err, to_err, commit;
  logic tmo_expire;

  assign len_ok   = (i_Rx_Byte != 8'd0) && (i_Rx_Byte <= 8'(MAX_LEN));
  assign csum_ok  = (i_Rx_Byte == csum);
  // Output register can take a frame if empty or being drained this cycle.
  assign out_free = !o_Valid || i_Ready;

  assign len_err  = i_Rx_DV && (state == S_LEN)  && !len_ok;
  assign csum_err = i_Rx_DV && (state == S_CSUM) && !csum_ok;
  assign commit   = i_Rx_DV && (state == S_CSUM) && csum_ok && out_free;
  assign ovr_err  = i_Rx_DV && (state == S_CSUM) && csum_ok && !out_free;
  assign to_err   = tmo_expire && (state != S_HUNT);

  assign o_Busy   = (state != S_HUNT);

  // Whether the byte in this cycle leaves the parser inside a frame; such a
  // byte re-arms the watchdog, any other byte or idling in hunt disarms it.
  always_comb begin
    next_busy = 1'b0;
    case (state)
      S_HUNT: next_busy = (i_Rx_Byte == SYNC_BYTE);
      S_LEN:  next_busy = len_ok;
      S_DATA: next_busy = 1'b1;
      S_CSUM: next_busy = 1'b0;
    endcase
  end

  uart_frame_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_Load  (i_Rx_DV && next_busy),
    .i_Clr   (i_Rx_DV || (state == S_HUNT)),
    .o_Expire(tmo_expire)
  );

  // Parser state and output register
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= S_HUNT;
      len_q     <= '0;
      idx       <= '0;
      csum      <= '0;
      o_Valid   <= 1'b0;
      o_Payload <= '0;
      o_Len     <= '0;
      o_Err     <= 1'b0;
    end else begin
      // The error sources are mutually exclusive: all but the timeout need a DV.
      o_Err <= len_err || csum_err || ovr_err || to_err;

      if (o_Valid && i_Ready) begin
        o_Valid <= 1'b0;
      end
      if (commit) begin
        o_Valid   <= 1'b1;
        o_Payload <= work_buf;
        o_Len     <= len_q;
      end

      if (to_err) begin
        state <= S_HUNT;
      end else if (i_Rx_DV) begin
        case (state)
          S_HUNT: begin
            if (i_Rx_Byte == SYNC_BYTE) state <= S_LEN;
          end
          S_LEN: begin
            if (len_ok) begin
              len_q <= i_Rx_Byte[LEN_W-1:0];
              csum  <= i_Rx_Byte;
              idx   <= '0;
              state <= S_DATA;
            end else begin
              state <= S_HUNT;
            end
          end
          S_DATA: begin
            csum <= csum ^ i_Rx_Byte;
            idx  <= idx + 1'b1;
            if (idx == len_q - 4'd1) state <= S_CSUM;
          end
          S_CSUM: begin
            state <= S_HUNT;
          end
        endcase
      end
    end
  end

  // Working payload buffer; cleared at every accepted LEN byte, so it needs
  // no reset and can never leak bytes of an earlier frame.
  always_ff @(posedge i_Clock) begin
    if (i_Rx_DV && (state == S_LEN) && len_ok) begin
      work_buf <= '0;
    end else if (i_Rx_DV && (state == S_DATA)) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (idx == LEN_W'(i)) work_buf[i*8 +: 8] <= i_Rx_Byte;
      end
    end
  end

`ifdef UART_FRAME_STATS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Cnt_Csum_Err <= '0;
      o_Cnt_Timeout  <= '0;
      o_Cnt_Overrun  <= '0;
    end else if (i_Cnt_Clr) begin
      o_Cnt_Csum_Err <= '0;
      o_Cnt_Timeout  <= '0;
      o_Cnt_Overrun  <= '0;
    end else begin
      if (len_err || csum_err) o_Cnt_Csum_Err <= sat_inc(o_Cnt_Csum_Err);
      if (to_err)              o_Cnt_Timeout  <= sat_inc(o_Cnt_Timeout);
      if (ovr_err)             o_Cnt_Overrun  <= sat_inc(o_Cnt_Overrun);
    end
  end
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: directed and randomized checks of uart_frame_ctrl.
module tb_uart_frame_ctrl;

  localparam int         MAX_LEN = 6;
  localparam int         TO      = 64;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 dv;
  logic [7:0]           rx_byte;
  logic                 ready;
  logic                 valid;
  logic [MAX_LEN*8-1:0] payload;
  logic [3:0]           len;
  logic                 err;
  logic                 busy;

  int checks   = 0;
  int errors   = 0;
  int err_seen = 0;
  int rd_idx   = 0;

  typedef struct packed {
    logic [3:0]  len;
    logic [47:0] pl;
  } frm_t;
  frm_t rxq[$];

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .SYNC_BYTE   (SYNC),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .i_Clock  (clk),
    .i_Rst_n  (rst_n),
    .i_Rx_DV  (dv),
    .i_Rx_Byte(rx_byte),
    .o_Valid  (valid),
    .i_Ready  (ready),
    .o_Payload(payload),
    .o_Len    (len),
    .o_Err    (err),
    .o_Busy   (busy)
  );

  // Observe error pulses and accepted frames away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_seen++;
      if (valid && ready) rxq.push_back({len, payload});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    dv      = 1'b1;
    rx_byte = b;
    tick();
    dv      = 1'b0;
    rx_byte = 8'h00;
  endtask

  initial begin
    int e0;
    int exp_err;
    rst_n   = 1'b0;
    dv      = 1'b0;
    rx_byte = 8'h00;
    ready   = 1'b1;
    idle(3);

    // Reset state
    chk("rst_valid", valid, 0);
    chk("rst_payload", payload, 0);
    chk("rst_len", len, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(2);

    // Good frame: A5 03 10 20 30 csum 03
    e0 = err_seen;
    send(SYNC); send(8'h03); send(8'h10); send(8'h20); send(8'h30);
    chk("good_pre_valid", valid, 0);
    chk("good_busy_mid", busy, 1);
    send(8'h03);
    chk("good_valid", valid, 1);
    chk("good_len", len, 3);
    chk("good_payload", payload, 48'h000000302010);
    chk("good_busy_end", busy, 0);
    tick();
    chk("good_drained", valid, 0);
    chk("good_payload_kept", payload, 48'h000000302010);
    chk("good_no_err", err_seen - e0, 0);

    // Bad checksum then a good frame
    send(SYNC); send(8'h02); send(8'h11); send(8'h22); send(8'h00);
    chk("badcs_err", err, 1);
    chk("badcs_valid", valid, 0);
    chk("badcs_busy", busy, 0);
    tick();
    chk("badcs_err_pulse", err, 0);
    send(SYNC); send(8'h02); send(8'h11); send(8'h22); send(8'h31);
    chk("after_bad_valid", valid, 1);
    chk("after_bad_payload", payload, 48'h2211);
    chk("after_bad_len", len, 2);
    tick();

    // Length bounds
    send(SYNC); send(8'h00);
    chk("len0_err", err, 1);
    chk("len0_busy", busy, 0);
    tick();
    send(SYNC); send(8'h07);
    chk("len7_err", err, 1);
    chk("len7_busy", busy, 0);
    tick();
    send(SYNC); send(8'h06);
    for (int i = 1; i <= 6; i++) send(8'(i));
    send(8'h01);
    chk("len6_valid", valid, 1);
    chk("len6_len", len, 6);
    chk("len6_payload", payload, 48'h060504030201);
    chk("len6_err", err, 0);
    tick();

    // Timeout after idle
    send(SYNC); send(8'h02); send(8'hAA);
    idle(TO - 1);
    chk("to_pre_err", err, 0);
    chk("to_pre_busy", busy, 1);
    tick();
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    tick();

    // Byte landing exactly on the expiry cycle is consumed
    send(SYNC); send(8'h02); send(8'hAA);
    idle(TO - 1);
    send(8'hBB);
    chk("to_dv_err", err, 0);
    chk("to_dv_busy", busy, 1);
    send(8'h02 ^ 8'hAA ^ 8'hBB);
    chk("to_dv_valid", valid, 1);
    chk("to_dv_payload", payload, 48'hBBAA);
    tick();

    // Overrun with backpressure
    rd_idx = rxq.size();
    ready = 1'b0;
    send(SYNC); send(8'h01); send(8'h55); send(8'h54);
    chk("ovr_first_valid", valid, 1);
    send(SYNC); send(8'h01); send(8'h66); send(8'h67);
    chk("ovr_err", err, 1);
    chk("ovr_valid_held", valid, 1);
    chk("ovr_payload_held", payload, 48'h55);
    chk("ovr_len_held", len, 1);
    ready = 1'b1;
    tick();
    chk("ovr_drained", valid, 0);
    ready = 1'b0;
    send(SYNC); send(8'h01); send(8'h77); send(8'h76);
    send(SYNC); send(8'h01); send(8'h88);
    ready = 1'b1;
    send(8'h89);
    chk("drain_commit_valid", valid, 1);
    chk("drain_commit_payload", payload, 48'h88);
    chk("drain_commit_err", err, 0);
    tick();
    chk("drain_commit_done", valid, 0);
    chk("ovr_rx_count", rxq.size() - rd_idx, 3);
    if (rxq.size() - rd_idx == 3) begin
      chk("ovr_rx0", rxq[rd_idx].pl, 48'h55);
      chk("ovr_rx1", rxq[rd_idx+1].pl, 48'h77);
      chk("ovr_rx2", rxq[rd_idx+2].pl, 48'h88);
    end

    // Asynchronous reset mid-frame with a frame held
    ready = 1'b0;
    send(SYNC); send(8'h01); send(8'hC3); send(8'hC2);
    chk("rstmid_held", valid, 1);
    send(SYNC); send(8'h03); send(8'h01); send(8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", valid, 0);
    chk("rstmid_payload", payload, 0);
    chk("rstmid_len", len, 0);
    chk("rstmid_err", err, 0);
    chk("rstmid_busy", busy, 0);
    #2 rst_n = 1'b1;
    tick();
    ready = 1'b1;
    send(SYNC); send(8'h02); send(8'h09); send(8'h0A); send(8'h01);
    chk("post_rst_valid", valid, 1);
    chk("post_rst_len", len, 2);
    chk("post_rst_payload", payload, 48'h0A09);
    idle(2);

    // Randomized frames against the frame-level model
    rd_idx  = rxq.size();
    exp_err = err_seen;
    for (int f = 0; f < 150; f++) begin
      int          nj;
      int          ln;
      logic [7:0]  b;
      logic [7:0]  cs;
      logic [47:0] pl;
      bit          good;
      good = 1'b0;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h5A;
        send(b);
        idle($urandom_range(0, 2));
      end
      send(SYNC);
      idle($urandom_range(0, 2));
      ln = $urandom_range(0, 8);
      send(8'(ln));
      idle($urandom_range(0, 2));
      if (ln < 1 || ln > MAX_LEN) begin
        exp_err++;
      end else begin
        cs = 8'(ln);
        pl = '0;
        for (int j = 0; j < ln; j++) begin
          b  = 8'($urandom_range(0, 255));
          pl = pl | (48'(b) << (8 * j));
          cs = cs ^ b;
          send(b);
          idle($urandom_range(0, 2));
        end
        if ($urandom_range(0, 3) == 0) begin
          send(cs ^ 8'($urandom_range(1, 255)));
          exp_err++;
        end else begin
          send(cs);
          good = 1'b1;
        end
      end
      idle(2);
      chk("rand_err_count", err_seen, exp_err);
      chk("rand_frame_count", rxq.size() - rd_idx, good ? 1 : 0);
      if (good && (rxq.size() > rd_idx)) begin
        chk("rand_len", rxq[rd_idx].len, ln);
        chk("rand_payload", rxq[rd_idx].pl, pl);
      end
      rd_idx = rxq.size();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
